// File: rtl/boot_loader.sv
// boot_loader: streams a program image into instruction memory over a
// byte valid/ready link, then releases the core and supervises its traps.
// Ports: clk, rst_n (sync, active-low); in_valid/in_data/in_ready byte
// stream; mem_we/mem_waddr/mem_wdata word write port; core_rst to the
// core; exception_in from the core; reload/rerun control pulses;
// running, exc_code, err (01 too large, 10 checksum), trap_count.
// Option: BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst,
  input  logic [6:0]            exception_in,
  input  logic                  reload,
  input  logic                  rerun,
  output logic                  running,
  output logic [6:0]            exc_code,
  output logic [1:0]            err,
  output logic [7:0]            trap_count
);

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CSUM  = 3'd2,
`endif
    RUN   = 3'd3,
    FAULT = 3'd4
  } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t LOAD_DONE = CSUM;
`else
  localparam state_t LOAD_DONE = RUN;
`endif

  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

  state_t state, state_n;

  logic [1:0]            bcnt;
  logic [ADDR_WIDTH-1:0] widx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [23:0]           sh;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            acc;
`endif

  logic        take;
  logic        last_byte;
  logic [31:0] word;
  logic        clr;
  logic        wr;
  logic        hdr_ld;
  logic        trap;
  logic        load_n;
  logic [1:0]  err_n;

  always_comb begin
    state_n   = state;
    clr       = 1'b0;
    wr        = 1'b0;
    hdr_ld    = 1'b0;
    trap      = 1'b0;
    err_n     = err;
    take      = in_valid & in_ready;
    last_byte = take && (bcnt == 2'd3);
    // Earlier bytes sit in sh; the current byte completes the word.
    word      = {in_data, sh};
    unique case (state)
      HDR: begin
        if (last_byte) begin
          hdr_ld = 1'b1;
          if ({1'b0, word} > CAP) begin
            err_n   = 2'b01;
            state_n = FAULT;
          end else if (word == 32'd0) begin
            state_n = LOAD_DONE;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (last_byte) begin
          wr = 1'b1;
          if (widx == last_idx) state_n = LOAD_DONE;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CSUM: begin
        if (take) begin
          if (in_data == acc) begin
            state_n = RUN;
          end else begin
            err_n   = 2'b10;
            state_n = FAULT;
          end
        end
      end
`endif
      RUN: begin
        if (exception_in != 7'd0) begin
          trap    = 1'b1;
          state_n = FAULT;
        end
      end
      FAULT: begin
        if (rerun && (err == 2'b00)) state_n = RUN;
      end
      default: state_n = HDR;
    endcase
    // reload overrides everything, from any state
    if (reload) begin
      state_n = HDR;
      clr     = 1'b1;
      wr      = 1'b0;
      hdr_ld  = 1'b0;
      trap    = 1'b0;
      err_n   = 2'b00;
    end
    load_n = (state_n != RUN) && (state_n != FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HDR;
      bcnt       <= 2'd0;
      widx       <= '0;
      last_idx   <= '0;
      sh         <= 24'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      acc        <= 8'd0;
`endif
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= 32'd0;
      core_rst   <= 1'b1;
      running    <= 1'b0;
      exc_code   <= 7'd0;
      err        <= 2'b00;
      trap_count <= 8'd0;
    end else begin
      state    <= state_n;
      in_ready <= load_n;
      core_rst <= (state_n != RUN);
      running  <= (state_n == RUN);
      err      <= err_n;
      mem_we   <= wr;
      if (clr) begin
        bcnt <= 2'd0;
        widx <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        acc  <= 8'd0;
`endif
      end else begin
        if (take) begin
          bcnt <= bcnt + 2'd1;
          sh   <= {in_data, sh[23:8]};
`ifdef BOOT_LOADER_CHECKSUM_EN
          if (state == DATA) acc <= acc ^ in_data;
`endif
        end
        if (wr) begin
          mem_waddr <= widx;
          mem_wdata <= word;
          widx      <= widx + ADDR_WIDTH'(1);
        end
      end
      // N is already bounded to 1..2**ADDR_WIDTH when it is used
      if (hdr_ld) last_idx <= word[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
      if (trap) begin
        exc_code <= exception_in;
        if (trap_count != 8'hFF) trap_count <= trap_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table-driven image loads plus hand sequences for
// reset, reload, rerun, checksum, trap and saturation behaviour.
module tb_boot_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic [6:0]    exception_in = 7'd0;
  logic          reload = 1'b0;
  logic          rerun = 1'b0;
  logic          running;
  logic [6:0]    exc_code;
  logic [1:0]    err;
  logic [7:0]    trap_count;

  boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .exception_in(exception_in),
    .reload(reload), .rerun(rerun), .running(running),
    .exc_code(exc_code), .err(err), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [AW-1:0] waq[$];
  logic [31:0]   wdq[$];
  logic [AW-1:0] eaq[$];
  logic [31:0]   edq[$];

  always @(negedge clk)
    if (mem_we) begin
      waq.push_back(mem_waddr);
      wdq.push_back(mem_wdata);
    end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    cyc(1);
    reload = 1'b0;
  endtask

  task automatic pulse_rerun();
    rerun = 1'b1;
    cyc(1);
    rerun = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    reload = 1'b0;
    rerun = 1'b0;
    exception_in = 7'd0;
    cyc(1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_running", running, 0);
    chk("rst_exc", exc_code, 0);
    chk("rst_err", err, 0);
    chk("rst_trap", trap_count, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("ready_after_rst", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bub);
    bit done;
    if (bub && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      cyc(1);
    end
    in_valid = 1'b1;
    in_data = b;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("byte_handshake_timeout", 0, 1);
  endtask

  // Model: each accepted word i lands at address i; checksum is XOR
  // of the data bytes.
  task automatic send_image(input logic [31:0] n, input bit good,
                            input bit bub);
    logic [31:0] w;
    logic [7:0] x;
    waq.delete(); wdq.delete(); eaq.delete(); edq.delete();
    x = 8'd0;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], bub);
    if (n > (32'd1 << AW)) return;
    for (int i = 0; i < int'(n); i++) begin
      w = $urandom;
      eaq.push_back(AW'(i));
      edq.push_back(w);
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], bub);
        x = x ^ w[8*j +: 8];
      end
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_byte(good ? x : (x ^ 8'h01), bub);
`else
    if (!good) x = 8'd0;
`endif
  endtask

  task automatic check_writes();
    cyc(2);
    chk("wr_count", waq.size(), eaq.size());
    for (int i = 0; i < eaq.size() && i < waq.size(); i++) begin
      chk("wr_addr", waq[i], eaq[i]);
      chk("wr_data", wdq[i], edq[i]);
    end
  endtask

  typedef struct {
    logic [31:0] n;
    logic [1:0]  e_err;
    logic        e_run;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] img[8];
    logic [7:0] x;
    int exp_trap;
    logic [6:0] exp_exc;

    tbl[0] = '{n: 32'd0,          e_err: 2'b00, e_run: 1'b1};
    tbl[1] = '{n: 32'd1,          e_err: 2'b00, e_run: 1'b1};
    tbl[2] = '{n: 32'd3,          e_err: 2'b00, e_run: 1'b1};
    tbl[3] = '{n: 32'd16,         e_err: 2'b00, e_run: 1'b1};
    tbl[4] = '{n: 32'd17,         e_err: 2'b01, e_run: 1'b0};
    tbl[5] = '{n: 32'hFFFF_FFFF,  e_err: 2'b01, e_run: 1'b0};
    tbl[6] = '{n: 32'h0001_0010,  e_err: 2'b01, e_run: 1'b0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      send_image(tbl[i].n, 1'b1, 1'b1);
      chk("tbl_err", err, tbl[i].e_err);
      chk("tbl_running", running, tbl[i].e_run);
      chk("tbl_core_rst", core_rst, !tbl[i].e_run);
      chk("tbl_in_ready", in_ready, 0);
      check_writes();
    end

    // Reference image 02 00 00 00 | 11 22 33 44 | 55 66 77 88
    do_reset();
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    img[4] = 8'h55; img[5] = 8'h66; img[6] = 8'h77; img[7] = 8'h88;
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    x = 8'd0;
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i], 0);
      x = x ^ img[i];
      if (i == 2) chk("no_we_mid_word", mem_we, 0);
      if (i == 3) begin
        chk("w0_we", mem_we, 1);
        chk("w0_addr", mem_waddr, 0);
        chk("w0_data", mem_wdata, 32'h4433_2211);
      end
      if (i == 7) begin
        chk("w1_we", mem_we, 1);
        chk("w1_addr", mem_waddr, 1);
        chk("w1_data", mem_wdata, 32'h8877_6655);
      end
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    chk("core_rst_before_csum", core_rst, 1);
    send_byte(x, 0);
`endif
    chk("run_core_rst", core_rst, 0);
    chk("run_running", running, 1);
    chk("run_in_ready", in_ready, 0);

    exception_in = 7'b0000100;
    cyc(1);
    exception_in = 7'd0;
    chk("exc_code", exc_code, 7'b0000100);
    chk("exc_trap", trap_count, 1);
    chk("exc_core_rst", core_rst, 1);
    chk("exc_running", running, 0);
    exception_in = 7'h55;
    cyc(1);
    exception_in = 7'd0;
    chk("exc_ignored_code", exc_code, 7'b0000100);
    chk("exc_ignored_trap", trap_count, 1);
    pulse_rerun();
    chk("rerun_running", running, 1);
    chk("rerun_core_rst", core_rst, 0);

    pulse_reload();
    chk("reload_run_core_rst", core_rst, 1);
    chk("reload_run_ready", in_ready, 1);
    send_image(32'd2, 1'b1, 1'b1);
    chk("reload_run_running", running, 1);
    check_writes();

`ifdef BOOT_LOADER_CHECKSUM_EN
    do_reset();
    send_image(32'd2, 1'b0, 1'b0);
    chk("bad_csum_err", err, 2'b10);
    chk("bad_csum_core_rst", core_rst, 1);
    chk("bad_csum_running", running, 0);
    pulse_rerun();
    chk("bad_csum_rerun_ign", running, 0);
    chk("bad_csum_rerun_rst", core_rst, 1);
    pulse_reload();
    chk("bad_csum_reload_err", err, 0);
    chk("bad_csum_reload_rdy", in_ready, 1);
    send_image(32'd1, 1'b1, 1'b1);
    chk("bad_csum_recover", running, 1);
    check_writes();
`endif

    // rst_n mid-word, then a full load from address 0
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0);
    send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    send_byte(8'hE5, 0); send_byte(8'hF6, 0);
    do_reset();
    send_image(32'd3, 1'b1, 1'b1);
    chk("after_rst_running", running, 1);
    check_writes();

    // reload mid-word discards the partial word and accumulator
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h5A, 0); send_byte(8'hC3, 0);
    pulse_reload();
    chk("reload_data_ready", in_ready, 1);
    send_image(32'd2, 1'b1, 1'b1);
    chk("reload_data_running", running, 1);
    check_writes();

    // reload and rerun together in FAULT: reload wins
    exception_in = 7'd1;
    cyc(1);
    exception_in = 7'd0;
    chk("fault_core_rst", core_rst, 1);
    reload = 1'b1;
    rerun = 1'b1;
    cyc(1);
    reload = 1'b0;
    rerun = 1'b0;
    chk("both_ready", in_ready, 1);
    chk("both_running", running, 0);
    chk("both_core_rst", core_rst, 1);
    chk("both_err", err, 0);
    chk("both_trap_kept", trap_count, 1);
    chk("both_exc_kept", exc_code, 1);

    // trap_count saturation
    do_reset();
    send_image(32'd1, 1'b1, 1'b0);
    exp_trap = 0;
    exp_exc = 7'd0;
    for (int k = 0; k < 260; k++) begin
      exp_exc = 7'($urandom_range(1, 127));
      exception_in = exp_exc;
      cyc(1);
      exception_in = 7'd0;
      exp_trap = (exp_trap < 255) ? exp_trap + 1 : 255;
      if ((k % 64) == 0 || k >= 253) begin
        chk("sat_trap", trap_count, exp_trap);
        chk("sat_exc", exc_code, exp_exc);
      end
      pulse_rerun();
    end
    chk("sat_final", trap_count, 255);
    chk("sat_running", running, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
